inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
Sequential RISC-V RV32I instruction encoder, the inverse of the instruction decoder. It accepts decoded fields over a valid/ready handshake and packs them into 32-bit instruction words. Each word is written to PRAM at consecutive addresses. Used by the boot/program loader and by self-test logic to build instruction images in PRAM.

Parameters:
ADDR_W, 10, PRAM word-address width.
BASE_ADDR, 0, first PRAM word address after reset or start.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  synchronous restart: address back to BASE_ADDR, clears count and error flags.
in_valid  input  1  field set valid.
in_ready  output  1  encoder can accept a field set.
fmt  input  3  format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
opcode  input  7  placed at inst[6:0].
dest_addr  input  5  rd.
rd_sel_a  input  5  rs1.
rd_sel_b  input  5  rs2.
func_three  input  3  funct3.
func_seven  input  7  funct7 (R-type only).
imm  input  32  full sign-extended immediate value; the encoder selects and scatters the bits.
pram_we  output  1  PRAM write strobe.
pram_addr  output  ADDR_W  PRAM word address.
pram_wdata  output  32  encoded instruction.
pram_busy  input  1  PRAM stall; a write completes on a rising edge where pram_we=1 and pram_busy=0.
count  output  ADDR_W+1  number of words written since reset or start.
err_fmt  output  1  sticky: an illegal fmt was received.
err_imm  output  1  sticky: an immediate was out of range (only with the optional feature).

Behaviour:
- Reset values (asynchronous):
  - State IDLE, in_ready=1, pram_we=0.
  - pram_addr=BASE_ADDR, pram_wdata=0, count=0, err_fmt=0, err_imm=0.
- FSM states: IDLE, ENC, WR, FULL.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid and in_ready) registers all field inputs; next state is ENC.
- ENC:
  - in_ready=0.
  - Legal fmt: encoded word registered into pram_wdata; next state WR.
  - Illegal fmt (6 or 7): set err_fmt, no write; next state IDLE.
- WR:
  - pram_we=1; pram_addr and pram_wdata held stable while pram_busy=1.
  - On completion, count increments.
  - If pram_addr was 2^ADDR_W-1, next state is FULL and the address is not incremented.
  - Otherwise pram_addr increments and next state is IDLE.
- FULL:
  - in_ready=0, no writes.
  - Exited only by start or rst.
- Latency and throughput:
  - Handshake at edge N: pram_we is high during the cycle following edge N+1.
  - Peak throughput is one word per 3 cycles.
- Encoding layout (inst bit ranges):
  - R: f7[31:25] rs2[24:20] rs1[19:15] f3[14:12] rd[11:7] op[6:0].
  - I: imm[11:0] at [31:20], then rs1, f3, rd, op.
  - S: imm[11:5] at [31:25], rs2, rs1, f3, imm[4:0] at [11:7], op.
  - B: imm[12], imm[10:5] at [31:25]; rs2, rs1, f3; imm[4:1], imm[11] at [11:7]; op.
  - U: imm[31:12] at [31:12], rd, op.
  - J: imm[20], imm[10:1], imm[11], imm[19:12] at [31:12]; rd, op.
  - Unused bits: imm[0] is ignored for B and J; rs2 and f7 are ignored for I, U and J.
- start:
  - Has priority over everything else in every state.
  - in_ready is forced to 0 while start=1, so a simultaneous in_valid is dropped.
  - A pending write is aborted: pram_we=0 on the next cycle.
- rst asserted mid-write: immediate return to the reset values; the partial write is not counted.
- count saturates at 2^ADDR_W.

Optional Feature:
Macro INST_ENCODER_IMM_CHECK_EN.
- Defined: in ENC, the immediate is range-checked by format:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check.
  - On failure: set err_imm, no write, return to IDLE.
- Not defined: immediates are silently truncated; err_imm is tied to 0.

Test Plan:
- I-type, fmt=1: op=0x13, rd=5, rs1=6, f3=0, imm=0xFFFFFFFF -> one write, pram_addr=0, pram_wdata=0xFFF30293, count=1.
- R-type, fmt=0: op=0x33, rd=1, rs1=2, rs2=3, f3=0, f7=0, then B-type, fmt=3: op=0x63, rs1=1, rs2=2, imm=0xFFFFFFFC, sent back-to-back -> writes 0x003100B3 at addr 0 and 0xFE208EE3 at addr 1; in_ready low for 2 cycles after each accept.
- J-type, fmt=5: op=0x6F, rd=1, imm=8, with pram_busy=1 for 3 cycles -> pram_we, addr and data stable for 4 cycles; wdata=0x008000EF; address increments exactly once.
- ADDR_W=2: 4 valid words -> state FULL, in_ready=0, count=4; a 5th in_valid is ignored; a start pulse gives pram_addr=0, count=0, in_ready=1.
- fmt=7 -> err_fmt=1 (sticky), no pram_we; start clears err_fmt. A start asserted while in WR -> pram_we=0 on the next cycle and count unchanged.
- With INST_ENCODER_IMM_CHECK_EN: I-type imm=0x00000800 -> err_imm=1, no write. Without the macro: writes imm field 0x800, i.e. inst[31:20]=0x800.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and writes them to
// consecutive PRAM addresses. Define INST_ENCODER_IMM_CHECK_EN to range-check immediates.
module inst_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        dest_addr,
  input  logic [4:0]        rd_sel_a,
  input  logic [4:0]        rd_sel_b,
  input  logic [2:0]        func_three,
  input  logic [6:0]        func_seven,
  input  logic [31:0]       imm,
  output logic              pram_we,
  output logic [ADDR_W-1:0] pram_addr,
  output logic [31:0]       pram_wdata,
  input  logic              pram_busy,
  output logic [ADDR_W:0]   count,
  output logic              err_fmt,
  output logic              err_imm,
  output logic [1:0]        state_dbg
);

  // Handshake: a field set transfers on a rising edge where in_valid && in_ready;
  // in_valid may change freely while in_ready is low, and start forces in_ready low.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST    = '1;
  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]  state;
  logic [2:0]  r_fmt;
  logic [6:0]  r_op;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [2:0]  r_f3;
  logic [6:0]  r_f7;
  logic [31:0] r_imm;
  logic [31:0] enc_word;
  logic        fmt_ok;
  logic        imm_ok;
  logic        err_imm_q;

  assign in_ready  = (state == S_IDLE) && !start;
  assign pram_we   = (state == S_WR);
  assign state_dbg = state;
  assign err_imm   = err_imm_q;

  always_comb begin
    enc_word = 32'h0;
    fmt_ok   = 1'b1;
    case (r_fmt)
      3'd0: enc_word = {r_f7, r_rs2, r_rs1, r_f3, r_rd, r_op};
      3'd1: enc_word = {r_imm[11:0], r_rs1, r_f3, r_rd, r_op};
      3'd2: enc_word = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], r_op};
      3'd3: enc_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3,
                        r_imm[4:1], r_imm[11], r_op};
      3'd4: enc_word = {r_imm[31:12], r_rd, r_op};
      3'd5: enc_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_op};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef INST_ENCODER_IMM_CHECK_EN
  // Upper bits must be a pure sign extension of the encodable field.
  always_comb begin
    imm_ok = 1'b1;
    case (r_fmt)
      3'd1, 3'd2: imm_ok = (&r_imm[31:11]) | ~(|r_imm[31:11]);
      3'd3:       imm_ok = ((&r_imm[31:12]) | ~(|r_imm[31:12])) & ~r_imm[0];
      3'd4:       imm_ok = ~(|r_imm[11:0]);
      3'd5:       imm_ok = ((&r_imm[31:20]) | ~(|r_imm[31:20])) & ~r_imm[0];
      default:    imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pram_addr  <= BASE;
      pram_wdata <= 32'h0;
      count      <= '0;
      err_fmt    <= 1'b0;
      err_imm_q  <= 1'b0;
      r_fmt      <= 3'd0;
      r_op       <= 7'd0;
      r_rd       <= 5'd0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_f3       <= 3'd0;
      r_f7       <= 7'd0;
      r_imm      <= 32'h0;
    end else if (start) begin
      // Restart wins over any in-flight write, which is dropped uncounted.
      state     <= S_IDLE;
      pram_addr <= BASE;
      count     <= '0;
      err_fmt   <= 1'b0;
      err_imm_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r_fmt <= fmt;
            r_op  <= opcode;
            r_rd  <= dest_addr;
            r_rs1 <= rd_sel_a;
            r_rs2 <= rd_sel_b;
            r_f3  <= func_three;
            r_f7  <= func_seven;
            r_imm <= imm;
            state <= S_ENC;
          end
        end
        S_ENC: begin
          if (!fmt_ok) begin
            err_fmt <= 1'b1;
            state   <= S_IDLE;
          end else if (!imm_ok) begin
            err_imm_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            pram_wdata <= enc_word;
            state      <= S_WR;
          end
        end
        S_WR: begin
          if (!pram_busy) begin
            if (count != CNT_MAX) count <= count + 1'b1;
            // The last address is kept so the image end stays visible in FULL.
            if (pram_addr == LAST) begin
              state <= S_FULL;
            end else begin
              pram_addr <= pram_addr + 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_FULL:  state <= S_FULL;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder (ADDR_W=2 so the FULL state is reached often):
// directed vectors from the field layout, then randomized transactions against a model.
module tb_inst_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    fmt = '0;
  logic [6:0]    opcode = '0;
  logic [4:0]    dest_addr = '0;
  logic [4:0]    rd_sel_a = '0;
  logic [4:0]    rd_sel_b = '0;
  logic [2:0]    func_three = '0;
  logic [6:0]    func_seven = '0;
  logic [31:0]   imm = '0;
  logic          pram_we;
  logic [AW-1:0] pram_addr;
  logic [31:0]   pram_wdata;
  logic          pram_busy = 1'b0;
  logic [AW:0]   count;
  logic          err_fmt;
  logic          err_imm;
  logic [1:0]    state_dbg;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .dest_addr(dest_addr), .rd_sel_a(rd_sel_a),
    .rd_sel_b(rd_sel_b), .func_three(func_three), .func_seven(func_seven), .imm(imm),
    .pram_we(pram_we), .pram_addr(pram_addr), .pram_wdata(pram_wdata),
    .pram_busy(pram_busy), .count(count), .err_fmt(err_fmt), .err_imm(err_imm),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state and reference model
  int n_vec = 0;
  int n_err = 0;
  int m_addr = 0;
  int m_count = 0;
  bit m_full = 0;
  bit m_err_fmt = 0;
  bit m_err_imm = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  // Word built by shifting each field to its documented bit position.
  function automatic logic [31:0] ref_word(input int f, input logic [31:0] op, input logic [31:0] rd,
                                           input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [31:0] f3, input logic [31:0] f7,
                                           input logic [31:0] im);
    logic [31:0] w;
    w = op;
    case (f)
      0: w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      1: w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | (fld(im, 11, 0) << 20);
      2: w = w | (fld(im, 4, 0) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
               | (fld(im, 11, 5) << 25);
      3: w = w | (fld(im, 11, 11) << 7) | (fld(im, 4, 1) << 8) | (f3 << 12) | (rs1 << 15)
               | (rs2 << 20) | (fld(im, 10, 5) << 25) | (fld(im, 12, 12) << 31);
      4: w = w | (rd << 7) | (fld(im, 31, 12) << 12);
      5: w = w | (rd << 7) | (fld(im, 19, 12) << 12) | (fld(im, 11, 11) << 20)
               | (fld(im, 10, 1) << 21) | (fld(im, 20, 20) << 31);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Encodable ranges expressed as signed intervals and alignment.
  function automatic bit imm_legal(input int f, input logic [31:0] im);
`ifdef INST_ENCODER_IMM_CHECK_EN
    int s;
    s = $signed(im);
    case (f)
      1, 2:    return (s >= -2048) && (s <= 2047);
      3:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      4:       return (im % 4096) == 0;
      5:       return (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
      default: return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_restart();
    m_addr = 0;
    m_count = 0;
    m_full = 0;
    m_err_fmt = 0;
    m_err_imm = 0;
  endfunction

  // driver tasks (called at a negedge, inputs change away from the rising edge)
  task automatic handshake(input int f, input logic [31:0] op, input logic [31:0] rd,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] f3, input logic [31:0] f7,
                           input logic [31:0] im);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("hs_ready", in_ready, 1);
    fmt = 3'(f);
    opcode = op[6:0];
    dest_addr = rd[4:0];
    rd_sel_a = rs1[4:0];
    rd_sel_b = rs2[4:0];
    func_three = f3[2:0];
    func_seven = f7[6:0];
    imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input int f, input logic [31:0] op, input logic [31:0] rd,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] f3, input logic [31:0] f7,
                      input logic [31:0] im, input int busy_k,
                      input bit use_lit, input logic [31:0] lit);
    bit legal;
    logic [31:0] exp_w;
    legal = (f < 6) && imm_legal(f, im);
    exp_w = use_lit ? lit : ref_word(f, op, rd, rs1, rs2, f3, f7, im);
    handshake(f, op, rd, rs1, rs2, f3, f7, im);
    pram_busy = (busy_k > 0);
    @(negedge clk);
    check("enc_ready", in_ready, 0);
    check("enc_we", pram_we, 0);
    if (!legal) begin
      if (f >= 6) m_err_fmt = 1;
      else m_err_imm = 1;
      pram_busy = 1'b0;
      @(negedge clk);
      check("skip_we", pram_we, 0);
      check("skip_ready", in_ready, 1);
      check("err_fmt", err_fmt, m_err_fmt);
      check("err_imm", err_imm, m_err_imm);
      check("skip_count", count, m_count);
      return;
    end
    exp_q.push_back(exp_w);
    for (int b = 0; b <= busy_k; b++) begin
      @(negedge clk);
      check("wr_we", pram_we, 1);
      check("wr_ready", in_ready, 0);
      check("wr_addr", pram_addr, m_addr);
      check("wr_data", pram_wdata, exp_q[0]);
      @(posedge clk);
      #1;
      pram_busy = (b + 1 < busy_k);
    end
    void'(exp_q.pop_front());
    if (m_count < DEPTH) m_count++;
    if (m_addr == DEPTH - 1) m_full = 1;
    else m_addr++;
    @(negedge clk);
    check("post_we", pram_we, 0);
    check("post_count", count, m_count);
    check("post_addr", pram_addr, m_addr);
    check("post_ready", in_ready, !m_full);
    check("post_err_fmt", err_fmt, m_err_fmt);
    check("post_err_imm", err_imm, m_err_imm);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    in_valid = 1'b1;
    #1;
    check("start_ready", in_ready, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    model_restart();
    @(negedge clk);
    check("rs_addr", pram_addr, m_addr);
    check("rs_count", count, m_count);
    check("rs_ready", in_ready, 1);
    check("rs_we", pram_we, 0);
    check("rs_err_fmt", err_fmt, 0);
    check("rs_err_imm", err_imm, 0);
  endtask

  task automatic full_ignore(input int cycles);
    in_valid = 1'b1;
    fmt = 3'd1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("full_ready", in_ready, 0);
      check("full_we", pram_we, 0);
      check("full_count", count, m_count);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_random();
    int f;
    int mode;
    logic [31:0] im;
    f = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(6, 7);
    mode = $urandom_range(0, 2);
    if (mode == 0) im = $urandom;
    else if (mode == 1) im = 32'($urandom_range(0, 8191)) - 32'd4096;
    else im = $urandom & 32'hFFFF_F000;
    send(f, $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127), im,
         $urandom_range(0, 2), 1'b0, 32'h0);
  endtask

  // main sequence and final report
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_we", pram_we, 0);
    check("rst_addr", pram_addr, 0);
    check("rst_wdata", pram_wdata, 0);
    check("rst_count", count, 0);
    check("rst_err_fmt", err_fmt, 0);
    check("rst_err_imm", err_imm, 0);
    rst = 1'b0;
    @(negedge clk);

    send(1, 32'h13, 5, 6, 0, 0, 0, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFF3_0293);
    start_pulse();
    send(0, 32'h33, 1, 2, 3, 0, 0, 32'h0, 0, 1'b1, 32'h0031_00B3);
    send(3, 32'h63, 0, 1, 2, 0, 0, 32'hFFFF_FFFC, 0, 1'b1, 32'hFE20_8EE3);
    send(5, 32'h6F, 1, 0, 0, 0, 0, 32'h8, 3, 1'b1, 32'h0080_00EF);
    send(4, 32'h37, 7, 0, 0, 0, 0, 32'hABCD_E000, 0, 1'b0, 32'h0);
    full_ignore(4);
    start_pulse();

    send(7, 32'h13, 1, 1, 1, 0, 0, 32'h0, 0, 1'b0, 32'h0);
    send(2, 32'h23, 0, 3, 4, 2, 0, 32'h7F5, 1, 1'b0, 32'h0);
    start_pulse();

    send(1, 32'h13, 0, 0, 0, 0, 0, 32'h0000_0800, 0, 1'b1, 32'h8000_0013);
    start_pulse();

    // start during a write: the write is dropped and nothing is counted
    handshake(5, 32'h6F, 1, 0, 0, 0, 0, 32'h8);
    @(negedge clk);
    @(negedge clk);
    check("ab_we_before", pram_we, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_restart();
    @(negedge clk);
    check("ab_we_after", pram_we, 0);
    check("ab_count", count, 0);
    check("ab_addr", pram_addr, 0);
    check("ab_ready", in_ready, 1);

    // reset during a write returns everything to reset values immediately
    send(0, 32'h33, 2, 3, 4, 0, 7'h20, 32'h0, 0, 1'b0, 32'h0);
    handshake(1, 32'h13, 9, 9, 0, 0, 0, 32'h123);
    pram_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rw_we", pram_we, 0);
    check("rw_count", count, 0);
    check("rw_addr", pram_addr, 0);
    check("rw_wdata", pram_wdata, 0);
    check("rw_ready", in_ready, 1);
    pram_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_restart();
    @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      if (m_full) begin
        full_ignore(2);
        start_pulse();
      end else if ($urandom_range(0, 14) == 0) begin
        start_pulse();
      end
      send_random();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
